sc_lane_scheduler: RTL
======================

Name: sc_lane_scheduler

Overview:
Sequences the shift operations of NUM_LANES background lane shift registers (road/river rows) from a single shared time base. Each lane has its own period (in prescaler ticks) and direction. When lanes fall due on the same tick, the block serialises them with round-robin priority, so at most one lane shifts per clock. It sits between the game top-level (start/pause/level inputs) and the per-lane shift register datapaths, and replaces per-lane timer state machines.

Parameters:
NUM_LANES, 4, number of lanes scheduled (2..8)
PRESCALE_MAX, 50000, CLOCK_50 cycles per tick (>=2)
PRESCALE_W, 16, prescaler counter width; must hold PRESCALE_MAX-1
PERIOD_W, 6, per-lane period width, in ticks

Ports:
SC_LANESCHEDULER_CLOCK_50  in  1  system clock, 50 MHz
SC_LANESCHEDULER_RESET_InLow  in  1  asynchronous reset, active low
SC_LANESCHEDULER_startButton_InLow  in  1  start request, active low, level
SC_LANESCHEDULER_pause_InLow  in  1  freeze scheduling, active low, level
SC_LANESCHEDULER_period_In  in  NUM_LANES*PERIOD_W  lane i period at bits [i*PERIOD_W +: PERIOD_W]
SC_LANESCHEDULER_dir_In  in  NUM_LANES  lane direction: 1 = left, 0 = right
SC_LANESCHEDULER_clear_OutLow  out  1  clears all lane registers, active low
SC_LANESCHEDULER_shiftselection_Out  out  2*NUM_LANES  lane i code at bits [2i+1:2i]: 11 hold, 10 shift right, 01 shift left
SC_LANESCHEDULER_tick_Out  out  1  one-cycle pulse on each prescaler wrap
SC_LANESCHEDULER_overrun_Out  out  NUM_LANES  sticky per-lane overrun flag

Behaviour:
- Reset (async, RESET_InLow=0):
  - State goes to CLEAR.
  - Prescaler, lane counters, pending, rr_ptr and overrun all go to 0.
  - Outputs: clear_OutLow=0, all shiftselection=11, tick_Out=0.
- FSM states: CLEAR, IDLE, RUN, PAUSE.
  - CLEAR: clear_OutLow=0 for exactly one cycle, then IDLE.
  - IDLE: clear_OutLow=1, all lanes hold, counters frozen. startButton_InLow=0 sampled moves to RUN on the next edge.
  - RUN: prescaler runs; lanes are scheduled and shifts issued. pause_InLow=0 moves to PAUSE.
  - PAUSE: prescaler, lane counters and pending are frozen; no shifts issued. pause_InLow=1 returns to RUN.
  - A new start (startButton_InLow=0) while in PAUSE goes to CLEAR, which flushes pending, counters and overrun.
- Prescaler:
  - In RUN, counts 0..PRESCALE_MAX-1.
  - At the cycle it wraps, tick_Out=1 for one cycle.
- Lane counters:
  - Each is PERIOD_W bits.
  - On tick: if counter==0, set pending[i] and reload with period_i-1; otherwise decrement.
  - period_i=0 is treated as 1 (lane due every tick).
  - Period is sampled only at reload.
  - On entry to RUN from IDLE, counters are loaded with period_i-1.
- Issue:
  - Registered output. In RUN, if any pending bit is set, select the lowest index j, searching cyclically from rr_ptr.
  - Next cycle: shiftselection[j] = dir_j ? 01 : 10 for exactly one cycle; pending[j] cleared; rr_ptr = (j+1) mod NUM_LANES.
  - All other lanes read 11.
  - At most one non-11 code appears per cycle.
- Simultaneous events:
  - A lane due on the same cycle its pending bit is being issued: issue wins, and pending is set again (no loss, no overrun).
  - A lane due while pending is still set and not being issued: pending stays 1 (no double shift) and the overrun event fires.
- Latency:
  - Tick to the first shift: 1 cycle.
  - k simultaneous due lanes complete in k consecutive cycles.
  - NUM_LANES <= PRESCALE_MAX, so pending always drains before the next tick.
- Pause or reset mid-issue: the output returns to 11 on the next cycle (pause) or immediately (reset).

Optional Feature:
LANE_SCHED_OVERRUN_EN
- Defined: overrun_Out[i] is set on the overrun event and stays set until CLEAR.
- Undefined: overrun_Out is tied to 0 and the detection logic is omitted. Scheduling behaviour is otherwise identical.

Decomposition:
- Package sc_lane_sched_pkg holds:
  - state encoding: CLEAR=0, IDLE=1, RUN=2, PAUSE=3
  - shift codes: SHIFT_HOLD=2'b11, SHIFT_RIGHT=2'b10, SHIFT_LEFT=2'b01
- One sub-module: sc_lane_rr_arbiter. It is combinational: NUM_LANES-bit pending plus rr_ptr in, one-hot grant plus valid out.
- Lane counters are a generate loop in the top.

Test Plan:
- Reset, then release: clear_OutLow=0 for 1 cycle, state reaches IDLE, all shiftselection=11. Hold start high for 1000 cycles: no tick_Out.
- PRESCALE_MAX=4, period_0=3, dir_0=1, start pulse: lane 0 shows 01 once every 12 cycles, 1 cycle after every third tick.
- All 4 lanes period=1, dir=0: each tick produces 10 on lanes 0,1,2,3 in consecutive cycles. Next tick's order starts at lane 0 because rr_ptr wraps.
- Pause asserted 2 cycles after a tick with 3 lanes pending: no issue while paused. After release, the remaining lanes issue in round-robin order with none lost.
- Overrun (macro on, PRESCALE_MAX=2, NUM_LANES=4, all periods 1): a pending bit collides with the next due event, so overrun_Out[3]=1, sticky until restart. Macro off: overrun_Out stays 0.
- Async reset during a lane-2 shift cycle: shiftselection returns to 11 immediately and clear_OutLow=0.

Source files
------------

// File: rtl/sc_lane_sched_pkg.sv
// -----------------------------------------------------------------------------
// sc_lane_sched_pkg
// Shared definitions for the lane scheduler: FSM state encoding, per-lane
// shift-selection codes and a helper that maps a lane direction to its code.
// -----------------------------------------------------------------------------
package sc_lane_sched_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } sched_state_t;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;

    // Direction 1 shifts the lane left, 0 shifts it right.
    function automatic logic [1:0] shift_code(input logic dir);
        return dir ? SHIFT_LEFT : SHIFT_RIGHT;
    endfunction

endpackage

// File: rtl/sc_lane_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sc_lane_rr_arbiter
// Combinational round-robin arbiter. Picks the lowest-indexed pending lane at
// or above rr_ptr; if none, wraps around and picks the lowest pending lane.
// Ports:
//   pending [NUM_LANES]  lanes requesting a shift
//   rr_ptr  [PTR_W]      lane with highest priority this cycle
//   grant   [NUM_LANES]  one-hot selected lane (zero when nothing pending)
//   valid                at least one lane is pending
// -----------------------------------------------------------------------------
module sc_lane_rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_LANES-1:0] pending,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic                 valid
);

    localparam logic [NUM_LANES-1:0] ONE = NUM_LANES'(1);

    logic [NUM_LANES-1:0] upper_mask;
    logic [NUM_LANES-1:0] req_hi;

    // Lanes at or above the pointer get first pick.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_mask
        assign upper_mask[gi] = (PTR_W'(gi) >= rr_ptr);
    end

    assign req_hi = pending & upper_mask;

    // x & -x isolates the lowest set bit.
    assign grant = (|req_hi) ? (req_hi & (~req_hi + ONE))
                             : (pending & (~pending + ONE));
    assign valid = |pending;

endmodule

// File: rtl/sc_lane_scheduler.sv
// -----------------------------------------------------------------------------
// sc_lane_scheduler
// Serialises the shift operations of NUM_LANES background lanes off one shared
// prescaler tick. Each lane counts its own period in ticks; due lanes are
// queued in a pending vector and issued one per clock in round-robin order.
// Optional build macro: LANE_SCHED_OVERRUN_EN enables sticky per-lane overrun
// flags; without it overrun_Out is tied low.
// Ports:
//   SC_LANESCHEDULER_CLOCK_50            system clock
//   SC_LANESCHEDULER_RESET_InLow         async reset, active low
//   SC_LANESCHEDULER_startButton_InLow   start request, active low
//   SC_LANESCHEDULER_pause_InLow         pause request, active low
//   SC_LANESCHEDULER_period_In           per-lane period in ticks (0 means 1)
//   SC_LANESCHEDULER_dir_In              per-lane direction, 1 = left
//   SC_LANESCHEDULER_clear_OutLow        clears lane registers, active low
//   SC_LANESCHEDULER_shiftselection_Out  per-lane code: 11 hold/10 right/01 left
//   SC_LANESCHEDULER_tick_Out            one-cycle pulse per prescaler wrap
//   SC_LANESCHEDULER_overrun_Out         sticky per-lane overrun flags
// -----------------------------------------------------------------------------
module sc_lane_scheduler
    import sc_lane_sched_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int PRESCALE_MAX = 50000,
    parameter int PRESCALE_W   = 16,
    parameter int PERIOD_W     = 6
) (
    input  logic                          SC_LANESCHEDULER_CLOCK_50,
    input  logic                          SC_LANESCHEDULER_RESET_InLow,
    input  logic                          SC_LANESCHEDULER_startButton_InLow,
    input  logic                          SC_LANESCHEDULER_pause_InLow,
    input  logic [NUM_LANES*PERIOD_W-1:0] SC_LANESCHEDULER_period_In,
    input  logic [NUM_LANES-1:0]          SC_LANESCHEDULER_dir_In,
    output logic                          SC_LANESCHEDULER_clear_OutLow,
    output logic [2*NUM_LANES-1:0]        SC_LANESCHEDULER_shiftselection_Out,
    output logic                          SC_LANESCHEDULER_tick_Out,
    output logic [NUM_LANES-1:0]          SC_LANESCHEDULER_overrun_Out
);

    localparam int PTR_W = $clog2(NUM_LANES);

    sched_state_t state_reg, state_next;

    logic [PRESCALE_W-1:0]  presc_reg, presc_next;
    logic [PERIOD_W-1:0]    cnt_reg  [NUM_LANES];
    logic [PERIOD_W-1:0]    cnt_next [NUM_LANES];
    logic [NUM_LANES-1:0]   pending_reg, pending_next;
    logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [2*NUM_LANES-1:0] shiftsel_reg, shiftsel_next;
    logic                   tick_reg;

    logic                   flush, load, running, wrap;
    logic [NUM_LANES-1:0]   due, grant, issue_vec;
    logic                   grant_valid, issue_en;
    logic [PTR_W-1:0]       grant_idx;

    // ---------------- FSM ----------------
    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) state_reg <= CLEAR;
        else                               state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        flush      = 1'b0;
        load       = 1'b0;
        running    = 1'b0;
        unique case (state_reg)
            CLEAR: begin
                flush      = 1'b1;
                state_next = IDLE;
            end
            IDLE: begin
                if (!SC_LANESCHEDULER_startButton_InLow) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                running = 1'b1;
                if (!SC_LANESCHEDULER_pause_InLow) state_next = PAUSE;
            end
            PAUSE: begin
                // A restart request outranks leaving pause.
                if (!SC_LANESCHEDULER_startButton_InLow) state_next = CLEAR;
                else if (SC_LANESCHEDULER_pause_InLow)   state_next = RUN;
            end
            default: state_next = CLEAR;
        endcase
    end

    // ---------------- Prescaler ----------------
    assign wrap = running && (presc_reg == PRESCALE_W'(PRESCALE_MAX - 1));

    always_comb begin
        presc_next = presc_reg;
        if (flush)        presc_next = '0;
        else if (wrap)    presc_next = '0;
        else if (running) presc_next = presc_reg + PRESCALE_W'(1);
    end

    // ---------------- Arbitration / issue ----------------
    sc_lane_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_arb (
        .pending (pending_reg),
        .rr_ptr  (rr_ptr_reg),
        .grant   (grant),
        .valid   (grant_valid)
    );

    assign issue_en  = running && grant_valid;
    assign issue_vec = issue_en ? grant : '0;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (grant[k]) grant_idx = PTR_W'(k);
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (flush) rr_ptr_next = '0;
        else if (issue_en)
            rr_ptr_next = (grant_idx == PTR_W'(NUM_LANES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    // ---------------- Per-lane counters, pending and codes ----------------
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [PERIOD_W-1:0] period_i;
        logic [PERIOD_W-1:0] reload_i;

        assign period_i = SC_LANESCHEDULER_period_In[gi*PERIOD_W +: PERIOD_W];
        // A zero period behaves as one: due on every tick.
        assign reload_i = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
        assign due[gi]  = wrap && (cnt_reg[gi] == '0);

        always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (flush)      cnt_next[gi] = '0;
            else if (load)  cnt_next[gi] = reload_i;
            else if (wrap)  cnt_next[gi] = (cnt_reg[gi] == '0) ? reload_i
                                                               : cnt_reg[gi] - PERIOD_W'(1);
        end

        // Issue clears the bit but a same-cycle due event sets it again, so a
        // lane being shifted as it falls due is never lost.
        always_comb begin
            pending_next[gi] = pending_reg[gi];
            if (flush)        pending_next[gi] = 1'b0;
            else if (running) pending_next[gi] = (pending_reg[gi] & ~issue_vec[gi]) | due[gi];
        end

        assign shiftsel_next[2*gi +: 2] = issue_vec[gi] ? shift_code(SC_LANESCHEDULER_dir_In[gi])
                                                        : SHIFT_HOLD;
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) begin
            presc_reg    <= '0;
            for (int k = 0; k < NUM_LANES; k++) cnt_reg[k] <= '0;
            pending_reg  <= '0;
            rr_ptr_reg   <= '0;
            shiftsel_reg <= '1;
            tick_reg     <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            cnt_reg      <= cnt_next;
            pending_reg  <= pending_next;
            rr_ptr_reg   <= rr_ptr_next;
            shiftsel_reg <= shiftsel_next;
            tick_reg     <= wrap;
        end
    end

    // ---------------- Optional overrun detection ----------------
`ifdef LANE_SCHED_OVERRUN_EN
    logic [NUM_LANES-1:0] overrun_reg;
    logic [NUM_LANES-1:0] overrun_evt;

    // Due again while still waiting and not being issued this cycle.
    assign overrun_evt = due & pending_reg & ~issue_vec;

    always_ff @(posedge SC_LANESCHEDULER_CLOCK_50 or negedge SC_LANESCHEDULER_RESET_InLow) begin
        if (!SC_LANESCHEDULER_RESET_InLow) overrun_reg <= '0;
        else if (flush)                    overrun_reg <= '0;
        else                               overrun_reg <= overrun_reg | overrun_evt;
    end

    assign SC_LANESCHEDULER_overrun_Out = overrun_reg;
`else
    assign SC_LANESCHEDULER_overrun_Out = '0;
`endif

    assign SC_LANESCHEDULER_clear_OutLow       = (state_reg != CLEAR);
    assign SC_LANESCHEDULER_shiftselection_Out = shiftsel_reg;
    assign SC_LANESCHEDULER_tick_Out           = tick_reg;

endmodule
